// File: rtl/memacc_pkg.sv
// Shared encodings for the memory-access stage: access sizes, misalign causes, FSM states.
// Latency: n/a (declarations and one pure helper function only).
// Backpressure: n/a.
package memacc_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;  // decoded as a word access

  localparam logic [4:0] CAUSE_LD_MISALIGN = 5'd4;
  localparam logic [4:0] CAUSE_ST_MISALIGN = 5'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } memacc_state_e;

  // Byte lane of the access within the word; low address bits below the
  // access size are dropped so an unchecked misaligned access stays in-word.
  function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] a);
    logic [1:0] off;
    case (size)
      SZ_BYTE: off = a;
      SZ_HALF: off = {a[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/memacc_ldfmt.sv
// Load formatter: picks the addressed lanes out of a read word and sign/zero-extends them.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module memacc_ldfmt
  import memacc_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        zext,
  output logic [31:0] ldata
);

  logic [31:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  // Extend the selected byte/half according to size and signedness.
  always_comb begin
    ldata = shifted;
    case (size)
      SZ_BYTE: ldata = {{24{~zext & shifted[7]}}, shifted[7:0]};
      SZ_HALF: ldata = {{16{~zext & shifted[15]}}, shifted[15:0]};
      default: ldata = shifted;
    endcase
  end

endmodule

// File: rtl/memacc_lsu.sv
// Load/store unit of the memory-access stage: one bus transaction per load/store, load alignment, misalign trap.
// Latency: store 1 stall cycle, load 2 stall cycles minimum, plus one per cycle of gnt/rvalid latency.
// Backpressure: memacc_stall holds upstream and bubbles mem_wb; mem_req held until mem_gnt. Option: MEMACC_MISALIGN_TRAP_EN.
module memacc_lsu
  import memacc_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          cpurst,
  input  logic          exe2mem_load,
  input  logic          exe2mem_store,
  input  logic [1:0]    exe2mem_size,
  input  logic          exe2mem_unsigned,
  input  logic [31:0]   exe2mem_addr,
  input  logic [31:0]   exe2mem_sdata,
  input  logic          exe2mem_wr_reg,
  input  logic [4:0]    exe2mem_wr_regindex,
  input  logic [31:0]   exe2mem_wr_wdata,
  input  logic          mem_flush,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_wstrb,
  output logic [31:0]   mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic          memacc_stall,
  output logic          mem2wb_wr_reg,
  output logic [4:0]    mem2wb_wr_regindex,
  output logic [31:0]   mem2wb_wr_wdata,
  output logic          mem2wb_exp,
  output logic [4:0]    mem2wb_causecode,
  output logic [31:0]   mem2wb_mtval
);

  memacc_state_e state_q, state_d;
  logic [31:0]   ld_q;
  logic [31:0]   ld_fmt;
  logic          mem_op;
  logic          misalign;
  logic [1:0]    lane_off;
  logic [3:0]    st_strb;
  logic [31:0]   st_wdata;

  assign mem_op   = exe2mem_load | exe2mem_store;
  assign lane_off = lane_offset(exe2mem_size, exe2mem_addr[1:0]);

`ifdef MEMACC_MISALIGN_TRAP_EN
  assign misalign = mem_op &&
                    (((exe2mem_size == SZ_HALF) && exe2mem_addr[0]) ||
                     (exe2mem_size[1] && (exe2mem_addr[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  memacc_ldfmt u_ldfmt (
    .rdata   (ld_q),
    .addr_lo (lane_off),
    .size    (exe2mem_size),
    .zext    (exe2mem_unsigned),
    .ldata   (ld_fmt)
  );

  // Store lane strobes and lane-replicated write data.
  always_comb begin
    st_strb  = 4'hF;
    st_wdata = exe2mem_sdata;
    case (exe2mem_size)
      SZ_BYTE: begin
        st_strb  = 4'b0001 << lane_off;
        st_wdata = {4{exe2mem_sdata[7:0]}};
      end
      SZ_HALF: begin
        st_strb  = 4'b0011 << lane_off;
        st_wdata = {2{exe2mem_sdata[15:0]}};
      end
      default: begin
        st_strb  = 4'hF;
        st_wdata = exe2mem_sdata;
      end
    endcase
  end

  // State register; reset returns to IDLE even with a read in flight.
  always_ff @(posedge clk) begin
    if (cpurst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Read data is captured only for the live load in WAIT, never for a drained orphan.
  always_ff @(posedge clk) begin
    if (cpurst)                                 ld_q <= '0;
    else if (state_q == ST_WAIT && mem_rvalid)  ld_q <= mem_rdata;
  end

  // Next state, bus request and writeback outputs; reset forces every output low.
  always_comb begin
    state_d            = state_q;
    mem_req            = 1'b0;
    mem_we             = 1'b0;
    mem_addr           = '0;
    mem_wstrb          = 4'h0;
    mem_wdata          = '0;
    memacc_stall       = 1'b0;
    mem2wb_wr_reg      = 1'b0;
    mem2wb_wr_regindex = exe2mem_wr_regindex;
    mem2wb_wr_wdata    = exe2mem_wr_wdata;
    mem2wb_exp         = 1'b0;
    mem2wb_causecode   = '0;
    mem2wb_mtval       = '0;

    case (state_q)
      ST_IDLE: begin
        if (misalign) begin
          mem2wb_exp       = ~mem_flush;
          mem2wb_causecode = exe2mem_load ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
          mem2wb_mtval     = exe2mem_addr;
        end else if (mem_op) begin
          mem_req      = 1'b1;
          memacc_stall = 1'b1;
          mem_we       = exe2mem_store;
          mem_addr     = {exe2mem_addr[AW-1:2], 2'b00};
          mem_wstrb    = exe2mem_store ? st_strb : 4'h0;
          mem_wdata    = exe2mem_store ? st_wdata : 32'h0;
          // A grant in the flush cycle still completes the bus transaction.
          if (mem_gnt) begin
            if (exe2mem_load) state_d = mem_flush ? ST_DRAIN : ST_WAIT;
            else              state_d = mem_flush ? ST_IDLE  : ST_DONE;
          end
        end else begin
          mem2wb_wr_reg = exe2mem_wr_reg & ~mem_flush;
        end
      end
      ST_WAIT: begin
        memacc_stall = 1'b1;
        if (mem_rvalid)     state_d = mem_flush ? ST_IDLE : ST_DONE;
        else if (mem_flush) state_d = ST_DRAIN;
      end
      ST_DONE: begin
        mem2wb_wr_reg = exe2mem_load & exe2mem_wr_reg & ~mem_flush;
        if (exe2mem_load) mem2wb_wr_wdata = ld_fmt;
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (mem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (cpurst) begin
      mem_req            = 1'b0;
      mem_we             = 1'b0;
      mem_addr           = '0;
      mem_wstrb          = 4'h0;
      mem_wdata          = '0;
      memacc_stall       = 1'b0;
      mem2wb_wr_reg      = 1'b0;
      mem2wb_wr_regindex = '0;
      mem2wb_wr_wdata    = '0;
      mem2wb_exp         = 1'b0;
      mem2wb_causecode   = '0;
      mem2wb_mtval       = '0;
    end
  end

endmodule

// File: tb/tb_memacc_lsu.sv
// Self-checking bench for memacc_lsu: directed scenarios plus randomized load/store/passthrough traffic.
// Latency: inputs driven 1ns after posedge, outputs sampled on negedge.
// Backpressure: bench plays the bus, driving gnt/rvalid on a fixed per-transaction schedule.
module tb_memacc_lsu;

  logic        clk = 1'b0;
  logic        cpurst;
  logic        exe2mem_load, exe2mem_store, exe2mem_unsigned;
  logic [1:0]  exe2mem_size;
  logic [31:0] exe2mem_addr, exe2mem_sdata, exe2mem_wr_wdata;
  logic        exe2mem_wr_reg;
  logic [4:0]  exe2mem_wr_regindex;
  logic        mem_flush;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        memacc_stall;
  logic        mem2wb_wr_reg;
  logic [4:0]  mem2wb_wr_regindex;
  logic [31:0] mem2wb_wr_wdata;
  logic        mem2wb_exp;
  logic [4:0]  mem2wb_causecode;
  logic [31:0] mem2wb_mtval;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  memacc_lsu #(.AW(32)) dut (
    .clk                 (clk),
    .cpurst              (cpurst),
    .exe2mem_load        (exe2mem_load),
    .exe2mem_store       (exe2mem_store),
    .exe2mem_size        (exe2mem_size),
    .exe2mem_unsigned    (exe2mem_unsigned),
    .exe2mem_addr        (exe2mem_addr),
    .exe2mem_sdata       (exe2mem_sdata),
    .exe2mem_wr_reg      (exe2mem_wr_reg),
    .exe2mem_wr_regindex (exe2mem_wr_regindex),
    .exe2mem_wr_wdata    (exe2mem_wr_wdata),
    .mem_flush           (mem_flush),
    .mem_req             (mem_req),
    .mem_we              (mem_we),
    .mem_addr            (mem_addr),
    .mem_wstrb           (mem_wstrb),
    .mem_wdata           (mem_wdata),
    .mem_gnt             (mem_gnt),
    .mem_rvalid          (mem_rvalid),
    .mem_rdata           (mem_rdata),
    .memacc_stall        (memacc_stall),
    .mem2wb_wr_reg       (mem2wb_wr_reg),
    .mem2wb_wr_regindex  (mem2wb_wr_regindex),
    .mem2wb_wr_wdata     (mem2wb_wr_wdata),
    .mem2wb_exp          (mem2wb_exp),
    .mem2wb_causecode    (mem2wb_causecode),
    .mem2wb_mtval        (mem2wb_mtval)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEMACC_MISALIGN_TRAP_EN
    return (int'(a[1:0]) % nbytes(sz)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_off(input logic [1:0] sz, input logic [31:0] a);
    int nb = nbytes(sz);
    return (int'(a[1:0]) / nb) * nb;
  endfunction

  function automatic logic [3:0] model_strb(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] s = 4'h0;
    int off = model_off(sz, a);
    for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + nbytes(sz));
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nbytes(sz)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns,
                                             input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v = 32'h0;
    int nb  = nbytes(sz);
    int off = model_off(sz, a);
    for (int j = 0; j < nb; j++) v[8*j +: 8] = rd[8*(off + j) +: 8];
    if (!uns && nb < 4 && v[8*nb - 1])
      for (int j = nb; j < 4; j++) v[8*j +: 8] = 8'hFF;
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    exe2mem_load = 0; exe2mem_store = 0; exe2mem_size = 0; exe2mem_unsigned = 0;
    exe2mem_addr = 0; exe2mem_sdata = 0; exe2mem_wr_reg = 0;
    exe2mem_wr_regindex = 0; exe2mem_wr_wdata = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req"},   32'(mem_req), 32'd0);
    chk({tag, ".we"},    32'(mem_we), 32'd0);
    chk({tag, ".addr"},  mem_addr, 32'd0);
    chk({tag, ".strb"},  32'(mem_wstrb), 32'd0);
    chk({tag, ".bwd"},   mem_wdata, 32'd0);
    chk({tag, ".stall"}, 32'(memacc_stall), 32'd0);
    chk({tag, ".wr"},    32'(mem2wb_wr_reg), 32'd0);
    chk({tag, ".idx"},   32'(mem2wb_wr_regindex), 32'd0);
    chk({tag, ".wd"},    mem2wb_wr_wdata, 32'd0);
    chk({tag, ".exp"},   32'(mem2wb_exp), 32'd0);
    chk({tag, ".cause"}, 32'(mem2wb_causecode), 32'd0);
    chk({tag, ".mtval"}, mem2wb_mtval, 32'd0);
  endtask

  task automatic passthru();
    logic       wr  = 1'($urandom);
    logic [4:0] idx = 5'($urandom);
    logic [31:0] wd = $urandom;
    set_idle();
    exe2mem_wr_reg = wr; exe2mem_wr_regindex = idx; exe2mem_wr_wdata = wd;
    @(negedge clk);
    chk("pt.req",   32'(mem_req), 32'd0);
    chk("pt.stall", 32'(memacc_stall), 32'd0);
    chk("pt.wr",    32'(mem2wb_wr_reg), 32'(wr));
    chk("pt.idx",   32'(mem2wb_wr_regindex), 32'(idx));
    chk("pt.wd",    mem2wb_wr_wdata, wd);
    chk("pt.exp",   32'(mem2wb_exp), 32'd0);
    next_cycle();
  endtask

  // One load/store with grant after gl idle cycles and rvalid after rl idle cycles.
  task automatic run_mem(input bit ld, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                         input int gl, input int rl);
    logic [4:0]  idx = 5'($urandom);
    exe2mem_load = ld; exe2mem_store = !ld; exe2mem_size = sz; exe2mem_unsigned = uns;
    exe2mem_addr = a; exe2mem_sdata = sd; exe2mem_wr_reg = 1'b1;
    exe2mem_wr_regindex = idx; exe2mem_wr_wdata = $urandom;
    if (model_mis(sz, a)) begin
      @(negedge clk);
      chk("mis.req",   32'(mem_req), 32'd0);
      chk("mis.stall", 32'(memacc_stall), 32'd0);
      chk("mis.exp",   32'(mem2wb_exp), 32'd1);
      chk("mis.cause", 32'(mem2wb_causecode), ld ? 32'd4 : 32'd6);
      chk("mis.mtval", mem2wb_mtval, a);
      chk("mis.wr",    32'(mem2wb_wr_reg), 32'd0);
      next_cycle();
    end else begin
      for (int k = 0; k <= gl; k++) begin
        mem_gnt = (k == gl);
        @(negedge clk);
        chk("req.req",   32'(mem_req), 32'd1);
        chk("req.stall", 32'(memacc_stall), 32'd1);
        chk("req.we",    32'(mem_we), 32'(!ld));
        chk("req.addr",  mem_addr, {a[31:2], 2'b00});
        chk("req.strb",  32'(mem_wstrb), ld ? 32'd0 : 32'(model_strb(sz, a)));
        if (!ld) chk("req.wdata", mem_wdata, model_wdata(sz, sd));
        next_cycle();
      end
      mem_gnt = 1'b0;
      if (ld) begin
        for (int k = 0; k <= rl; k++) begin
          mem_rvalid = (k == rl);
          mem_rdata  = (k == rl) ? rd : $urandom;
          @(negedge clk);
          chk("wait.req",   32'(mem_req), 32'd0);
          chk("wait.stall", 32'(memacc_stall), 32'd1);
          next_cycle();
        end
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
      end
      @(negedge clk);
      chk("done.stall", 32'(memacc_stall), 32'd0);
      chk("done.req",   32'(mem_req), 32'd0);
      chk("done.exp",   32'(mem2wb_exp), 32'd0);
      chk("done.wr",    32'(mem2wb_wr_reg), 32'(ld));
      if (ld) begin
        chk("done.idx",  32'(mem2wb_wr_regindex), 32'(idx));
        chk("done.data", mem2wb_wr_wdata, model_load(sz, uns, a, rd));
      end
      next_cycle();
    end
    set_idle();
  endtask

  initial begin
    cpurst = 1'b1; mem_flush = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    set_idle();
    // Reset: outputs low even with a live passthrough presented.
    exe2mem_wr_reg = 1; exe2mem_wr_regindex = 5'd7; exe2mem_wr_wdata = 32'hDEAD_BEEF;
    #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_all_zero("rst");
      next_cycle();
    end
    cpurst = 1'b0;
    set_idle();

    passthru();

    // LB at 0x1003, rvalid one cycle after grant.
    run_mem(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0);
    // SH at 0x2002 with grant two cycles late.
    run_mem(1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'hABCD_1234, 32'h0, 2, 0);
    // LW at 0x3001: trap, or a word load from 0x3000.
    run_mem(1'b1, 2'd2, 1'b0, 32'h0000_3001, 32'h0, 32'h1122_3344, 0, 0);
    // SW at 0x2001 and LHU at 0x2003 (misaligned when trapping).
    run_mem(1'b0, 2'd2, 1'b0, 32'h0000_2001, 32'h5566_7788, 32'h0, 0, 0);
    run_mem(1'b1, 2'd1, 1'b1, 32'h0000_2003, 32'h0, 32'h89AB_CDEF, 1, 2);

    // Flush in WAIT: LHU drained, following LW waits for the orphan rvalid.
    exe2mem_load = 1; exe2mem_size = 2'd1; exe2mem_unsigned = 1; exe2mem_addr = 32'h5002;
    exe2mem_wr_reg = 1; exe2mem_wr_regindex = 5'd3; mem_gnt = 1;
    @(negedge clk);
    chk("fl.req", 32'(mem_req), 32'd1);
    next_cycle();
    mem_gnt = 0; mem_flush = 1;
    @(negedge clk);
    chk("fl.wait.req", 32'(mem_req), 32'd0);
    chk("fl.wait.wr",  32'(mem2wb_wr_reg), 32'd0);
    next_cycle();
    mem_flush = 0;
    exe2mem_size = 2'd2; exe2mem_unsigned = 0; exe2mem_addr = 32'h6000; exe2mem_wr_regindex = 5'd9;
    for (int k = 1; k <= 3; k++) begin
      mem_rvalid = (k == 3);
      mem_rdata  = 32'hFFFF_0000;
      @(negedge clk);
      chk("drain.req",   32'(mem_req), 32'd0);
      chk("drain.stall", 32'(memacc_stall), 32'd0);
      chk("drain.wr",    32'(mem2wb_wr_reg), 32'd0);
      chk("drain.exp",   32'(mem2wb_exp), 32'd0);
      next_cycle();
    end
    mem_rvalid = 0;
    run_mem(1'b1, 2'd2, 1'b0, 32'h0000_6000, 32'h0, 32'hCAFE_F00D, 0, 1);

    // Reset in the middle of WAIT; the late rvalid must be ignored.
    exe2mem_load = 1; exe2mem_size = 2'd2; exe2mem_addr = 32'h7000;
    exe2mem_wr_reg = 1; exe2mem_wr_regindex = 5'd5; exe2mem_wr_wdata = 32'h1234_5678; mem_gnt = 1;
    @(negedge clk);
    chk("rw.req", 32'(mem_req), 32'd1);
    next_cycle();
    mem_gnt = 0; cpurst = 1;
    @(negedge clk);
    chk_all_zero("rstwait");
    next_cycle();
    cpurst = 0;
    set_idle();
    mem_rvalid = 1; mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    chk_all_zero("orphan");
    next_cycle();
    mem_rvalid = 0;
    run_mem(1'b0, 2'd0, 1'b0, 32'h0000_7001, 32'h0000_00A5, 32'h0, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      int kind = $urandom_range(0, 2);
      if (kind == 0) passthru();
      else run_mem(kind == 1, 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom,
                   $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memacc_lsu.md
# memacc_lsu

Memory-access stage load/store unit, directly upstream of the `mem_wb` pipeline register. It takes the held EX/MEM instruction, issues one data-bus transaction per load/store and aligns load data. It generates `memacc_stall`, which freezes upstream and bubbles `mem_wb`, and flags misaligned accesses as exceptions for writeback.

## Interface
Parameters:
- `AW`, 32, data-bus address width.

Ports:
- `clk` in 1: single clock.
- `cpurst` in 1: reset, synchronous, active-high.
- `exe2mem_load` / `exe2mem_store` in 1 each: the instruction is a load / store (never both).
- `exe2mem_size` in 2: 0 byte, 1 half, 2 word, 3 reserved (treated as word).
- `exe2mem_unsigned` in 1: zero-extend load (LBU/LHU).
- `exe2mem_addr` in 32: effective address.
- `exe2mem_sdata` in 32: store data, LSB-aligned.
- `exe2mem_wr_reg` / `exe2mem_wr_regindex` (5) / `exe2mem_wr_wdata` (32) in: ALU writeback passthrough.
- `mem_flush` in 1: kill the current instruction (trap/mret at writeback).
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out AW (word-aligned), `mem_wstrb` out 4, `mem_wdata` out 32: bus request.
- `mem_gnt` in 1: request accepted this cycle.
- `mem_rvalid` in 1, `mem_rdata` in 32: read response.
- `memacc_stall` out 1: hold upstream, bubble `mem_wb`.
- `mem2wb_wr_reg` out 1, `mem2wb_wr_regindex` out 5, `mem2wb_wr_wdata` out 32: to `mem_wb`.
- `mem2wb_exp` out 1, `mem2wb_causecode` out 5, `mem2wb_mtval` out 32: misalign exception.

## Operation
- Upstream holds all `exe2mem_*` inputs stable while `memacc_stall`=1.
- FSM states:
  - IDLE → WAIT: load issued and granted.
  - IDLE → DONE: store granted.
  - WAIT → DONE: `mem_rvalid`.
  - DONE → IDLE: always.
  - DRAIN → IDLE: `mem_rvalid`.
- IDLE with an aligned load/store: `mem_req`=1 and `memacc_stall`=1. `mem_req` stays high until `mem_gnt`.
- WAIT: `mem_req`=0 and `memacc_stall`=1. On `mem_rvalid`, `mem_rdata` is captured in `ld_q`.
- DONE: `memacc_stall`=0.
  - Load: `mem2wb_wr_wdata` is `ld_q` shifted right by 8·addr[1:0], then sign- or zero-extended per size.
  - Store: `mem2wb_wr_reg`=0.
- Non-memory instruction in IDLE: pure passthrough, no stall, no request.
- Store data is replicated across lanes: byte ×4, half ×2.
- `mem_wstrb` per size and address:
  - byte: `4'b0001<<a[1:0]`
  - half: `4'b0011<<a[1:0]`
  - word: `4'hF`
  - Loads drive `mem_wstrb`=0.
- `mem_addr` = {addr[AW-1:2],2'b00}.
- Misaligned access (half with a[0]=1, word with a[1:0]≠0):
  - No request, no stall.
  - `mem2wb_exp`=1, `mem2wb_mtval`=addr, `mem2wb_wr_reg`=0.
  - Cause 4 for load, 6 for store.
- `mem_flush` behaviour by state:
  - IDLE, not yet granted: request dropped next cycle.
  - IDLE, granted in the same cycle: counts as granted; the flush applies afterwards.
  - WAIT: go to DRAIN. DRAIN has stall=0, outputs killed, and absorbs the orphan `mem_rvalid` before any new request.
  - DONE: outputs killed, return to IDLE.
- Killed means `mem2wb_wr_reg`=0 and `mem2wb_exp`=0.

## Timing
- Reset cycle: all outputs 0; state returns to IDLE from any state, including mid-WAIT. The bus is reset by the same `cpurst`.
- Store with `mem_gnt` in the request cycle: stall for 1 cycle, result in the following (DONE) cycle.
- Load, minimum: request+grant in cycle 0, `rvalid` in cycle 1, DONE in cycle 2. That is 2 stall cycles.
- Each cycle of `mem_gnt` or `mem_rvalid` latency adds one stall cycle.
- At most one outstanding transaction.
- A new request may issue in the cycle after DONE, or in the cycle after DRAIN sees `rvalid`.
- All outputs are combinational from state, `ld_q` and held inputs. Only state and `ld_q` are registered.

## Configuration
- `MEMACC_MISALIGN_TRAP_EN` defined: misalignment trap as above.
- Not defined:
  - No alignment check.
  - Address LSBs are ignored per size: a[0] for half, a[1:0] for word.
  - Exception outputs tied to 0.

## Structure
- Shared package `memacc_pkg`:
  - size encodings;
  - cause constants `CAUSE_LD_MISALIGN`=4 and `CAUSE_ST_MISALIGN`=6;
  - FSM state enum.
- One sub-module, `memacc_ldfmt`: load lane extraction and extension. Pure combinational; inputs rdata, addr[1:0], size, unsigned.

## Test plan
- LB at 0x1003, rdata=0x80FF_0000, rvalid one cycle after grant → 2 stall cycles, then `mem2wb_wr_wdata`=0xFFFF_FF80.
- SH 0xABCD1234 at 0x2002, `mem_gnt` delayed 2 cycles → `mem_wstrb`=4'b1100, `mem_wdata`=0x1234_1234, `mem_req` held 3 cycles, 3 stall cycles, `mem2wb_wr_reg`=0.
- LW at 0x3001 with macro defined → no `mem_req`, no stall, `mem2wb_exp`=1, cause 4, mtval 0x3001.
- Same LW at 0x3001 with macro undefined → request to `mem_addr`=0x3000 and normal load result.
- LHU in WAIT, `mem_flush` asserted, rvalid 3 cycles later, next LW already waiting → LW `mem_req` rises only the cycle after the orphan rvalid, and the LHU never writes back.
- `cpurst` asserted during WAIT → the next cycle shows state IDLE and all outputs 0; the later rvalid is ignored.
